mem_burst_reader: RTL

- Sequential read engine for the 16-bit x 1024 dual-port block RAM wrappers.
- Accepts a (start address, length) command and drives the RAM read port.
- Absorbs the RAM's 1-cycle registered read latency and returns the words as a valid/ready stream with last-beat marking.
- Handles downstream backpressure without losing or duplicating data. It is the read-side counterpart of the bit-enable read-modify-write write path.

---
 rtl/mem_pkg.sv | 12 +
 rtl/mem_burst_reader_if.sv | 28 ++
 rtl/mem_rd_skid_fifo.sv | 48 ++++
 rtl/mem_burst_reader.sv | 91 +++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and read-engine state encoding for the block RAM wrappers
package mem_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;
endpackage

// File: rtl/mem_burst_reader_if.sv
// rtl/mem_burst_reader_if.sv - command, RAM read port and output stream bundle of the burst reader
interface mem_burst_reader_if;
  import mem_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, mem_dout, rd_ready,
    output cmd_ready, mem_en, mem_addr, rd_valid, rd_data, rd_last, busy, done
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, mem_dout, rd_ready,
    input  cmd_ready, mem_en, mem_addr, rd_valid, rd_data, rd_last, busy, done
  );
endinterface

// File: rtl/mem_rd_skid_fifo.sv
// rtl/mem_rd_skid_fifo.sv - 2-entry output buffer of {last, data} that absorbs the RAM read latency
module mem_rd_skid_fifo #(
  parameter int W = 17
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [1:0]   o_occ,
  output logic [W-1:0] o_head
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop  = i_pop && (r_occ != 2'd0);
  // A push into a full buffer is only legal when the same edge frees an entry.
  assign w_do_push = i_push && ((r_occ != 2'd2) || w_do_pop);
  assign o_occ     = r_occ;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - sequential burst read engine returning RAM words as a valid/ready stream
module mem_burst_reader
  import mem_pkg::*;
(
  input logic               i_clk,
  input logic               i_reset,
  mem_burst_reader_if.slave io_bus
);
  rd_state_t         r_state;
  rd_state_t         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [1:0]        w_occ;
  logic [DATA_W:0]   w_head;
  logic              w_pop;
  logic              w_issue;
  logic              w_accept;
  logic [2:0]        w_pending;

  assign w_pop     = io_bus.rd_valid && io_bus.rd_ready;
  assign w_accept  = io_bus.cmd_valid && io_bus.cmd_ready;
  assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = (io_bus.cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Only issue when the returning word is guaranteed a buffer slot.
        w_issue = (r_remaining != '0) && (w_pending < (3'd2 + {2'b00, w_pop}));
        if (w_issue && (r_remaining == 1)) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && w_head[DATA_W]) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remaining == 1);
      if (w_accept) begin
        r_addr      <= io_bus.cmd_addr;
        r_remaining <= io_bus.cmd_len;
      end else if (w_issue) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  mem_rd_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (r_inflight),
    .i_push_data ({r_inflight_last, io_bus.mem_dout}),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (w_head)
  );

  assign io_bus.cmd_ready = (r_state == IDLE);
  assign io_bus.busy      = (r_state != IDLE);
  assign io_bus.done      = (r_state == DONE);
  assign io_bus.mem_en    = w_issue;
  assign io_bus.mem_addr  = r_addr;
  assign io_bus.rd_valid  = (w_occ != 2'd0);
  assign io_bus.rd_data   = w_head[DATA_W-1:0];
  assign io_bus.rd_last   = w_head[DATA_W];
endmodule
